time_parameters_regs: RTL and testbench

//  Programmable store of the three timing intervals used by the traffic-light controller FSM:

---
 rtl/time_parameters_regs_pkg.sv | 24 ++
 rtl/time_parameters_regs.sv | 69 ++++++
 tb/tb_time_parameters_regs.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/time_parameters_regs_pkg.sv
// rtl/time_parameters_regs_pkg.sv - shared constants and types for the traffic-light timing registers
package time_parameters_regs_pkg;

    localparam int TIME_W = 4;

    typedef logic [TIME_W-1:0] time_t;

    typedef enum logic [1:0] {
        INT_BASE = 2'b00,
        INT_EXT  = 2'b01,
        INT_YEL  = 2'b10,
        INT_NONE = 2'b11
    } interval_e;

    localparam time_t DEF_BASE = 4'd6;
    localparam time_t DEF_EXT  = 4'd3;
    localparam time_t DEF_YEL  = 4'd2;

    // A zero program value means "restore the default", so a zero-length interval is never stored.
    function automatic time_t resolve_time(input time_t value, input time_t dflt);
        return (value == '0) ? dflt : value;
    endfunction

endpackage

// File: rtl/time_parameters_regs.sv
// rtl/time_parameters_regs.sv - programmable base/extended/yellow interval store with combinational read
module time_parameters_regs
    import time_parameters_regs_pkg::*;
#(
    parameter time_t T_BASE = DEF_BASE,
    parameter time_t T_EXT  = DEF_EXT,
    parameter time_t T_YEL  = DEF_YEL
) (
    input  logic              clock,
    input  logic              Reset_Sync,
    input  logic [1:0]        TP_Selector,
    input  logic [TIME_W-1:0] Time_Value,
    input  logic              Prog_Sync,
    input  logic [1:0]        Interval,
    output logic [TIME_W-1:0] Value
);

    time_t base_q;
    time_t ext_q;
    time_t yel_q;

    logic  wr_base;
    logic  wr_ext;
    logic  wr_yel;

    interval_e wr_sel;
    interval_e rd_sel;

    assign wr_sel = interval_e'(TP_Selector);
    assign rd_sel = interval_e'(Interval);

    always_comb begin
        wr_base = 1'b0;
        wr_ext  = 1'b0;
        wr_yel  = 1'b0;
        if (Prog_Sync) begin
            case (wr_sel)
                INT_BASE: wr_base = 1'b1;
                INT_EXT:  wr_ext  = 1'b1;
                INT_YEL:  wr_yel  = 1'b1;
                default:  ;
            endcase
        end
    end

    // Reset wins over a simultaneous program strobe.
    always_ff @(posedge clock) begin
        if (Reset_Sync) begin
            base_q <= T_BASE;
            ext_q  <= T_EXT;
            yel_q  <= T_YEL;
        end else begin
            if (wr_base) base_q <= resolve_time(Time_Value, T_BASE);
            if (wr_ext)  ext_q  <= resolve_time(Time_Value, T_EXT);
            if (wr_yel)  yel_q  <= resolve_time(Time_Value, T_YEL);
        end
    end

    always_comb begin
        Value = '0;
        case (rd_sel)
            INT_BASE: Value = base_q;
            INT_EXT:  Value = ext_q;
            INT_YEL:  Value = yel_q;
            default:  Value = '0;
        endcase
    end

endmodule

// File: tb/tb_time_parameters_regs.sv
// tb/tb_time_parameters_regs.sv - randomized bench with behavioural model for time_parameters_regs
module tb_time_parameters_regs;

    logic       clock = 1'b0;
    logic       Reset_Sync = 1'b0;
    logic [1:0] TP_Selector = 2'd0;
    logic [3:0] Time_Value = 4'd0;
    logic       Prog_Sync = 1'b0;
    logic [1:0] Interval = 2'd0;
    logic [3:0] Value;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl[3];
    bit mdl_valid = 1'b0;

    always #5 clock = ~clock;

    time_parameters_regs dut (
        .clock       (clock),
        .Reset_Sync  (Reset_Sync),
        .TP_Selector (TP_Selector),
        .Time_Value  (Time_Value),
        .Prog_Sync   (Prog_Sync),
        .Interval    (Interval),
        .Value       (Value)
    );

    function automatic int dflt(input int code);
        case (code)
            0:       return 6;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int expected(input logic [1:0] itv);
        if (itv == 2'd3) return 0;
        return mdl[itv];
    endfunction

    // Model: three integers, updated from the rules at each rising edge.
    always @(posedge clock) begin
        if (Reset_Sync === 1'b1) begin
            for (int i = 0; i < 3; i++) mdl[i] = dflt(i);
            mdl_valid = 1'b1;
        end else if (Prog_Sync === 1'b1 && TP_Selector != 2'd3) begin
            mdl[TP_Selector] = (Time_Value == 4'd0) ? dflt(int'(TP_Selector)) : int'(Time_Value);
        end
    end

    always @(negedge clock) begin
        if (mdl_valid) begin
            n_checks++;
            if (Value !== 4'(expected(Interval))) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t interval=%0d value=%0d required=%0d",
                         $time, Interval, Value, expected(Interval));
            end
        end
    end

    task automatic step(input bit r, input bit p, input logic [1:0] sel, input logic [3:0] tv);
        Reset_Sync  = r;
        Prog_Sync   = p;
        TP_Selector = sel;
        Time_Value  = tv;
        @(posedge clock);
        #1;
        Reset_Sync = 1'b0;
        Prog_Sync  = 1'b0;
    endtask

    task automatic check_lit(input string name, input logic [1:0] itv, input int req);
        @(negedge clock);
        #1;
        Interval = itv;
        #1;
        n_checks++;
        if (Value !== 4'(req)) begin
            n_fail++;
            $display("FAIL %s dut value=%0d required=%0d", name, Value, req);
        end
        n_checks++;
        if (expected(itv) != req) begin
            n_fail++;
            $display("FAIL %s_model value=%0d required=%0d", name, expected(itv), req);
        end
    endtask

    initial begin
        step(1, 0, 2'd0, 4'd0);
        check_lit("rst_base", 2'd0, 6);
        check_lit("rst_ext",  2'd1, 3);
        check_lit("rst_yel",  2'd2, 2);
        check_lit("rst_none", 2'd3, 0);

        step(0, 1, 2'd0, 4'd12);
        check_lit("prog_base", 2'd0, 12);
        check_lit("ext_kept",  2'd1, 3);

        step(0, 1, 2'd1, 4'd9);
        step(0, 1, 2'd2, 4'd5);
        check_lit("prog_ext",  2'd1, 9);
        check_lit("prog_yel",  2'd2, 5);
        check_lit("base_kept", 2'd0, 12);

        step(0, 1, 2'd0, 4'd0);
        check_lit("zero_base", 2'd0, 6);

        step(0, 1, 2'd3, 4'd15);
        check_lit("sel11_base", 2'd0, 6);
        check_lit("sel11_ext",  2'd1, 9);
        check_lit("sel11_yel",  2'd2, 5);

        step(0, 1, 2'd1, 4'd4);
        step(0, 1, 2'd1, 4'd4);
        step(0, 1, 2'd1, 4'd4);
        check_lit("held_prog", 2'd1, 4);

        step(1, 1, 2'd1, 4'd14);
        check_lit("rst_prio_ext", 2'd1, 3);
        check_lit("rst_prio_yel", 2'd2, 2);

        step(0, 1, 2'd2, 4'd7);
        step(0, 1, 2'd0, 4'd15);
        step(1, 0, 2'd0, 4'd0);
        check_lit("rerst_base", 2'd0, 6);
        check_lit("rerst_ext",  2'd1, 3);
        check_lit("rerst_yel",  2'd2, 2);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] tv;
            tv = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            Interval = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), tv);
        end

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
